// File: rtl/mul_seq_if.sv
// Bundle of signals around the mul_seq sequencer.
//   Operand side : in_valid / in_ready handshake carrying in_a, in_b.
//   Multiplier   : ld, a, b drive the shift-add multiplier; ry, rb come back from it.
//   Result side  : out_valid / out_ready handshake carrying the 2W-bit product out_p.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface mul_seq_if #(
  parameter int unsigned W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           ld;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] ry;
  logic [W-1:0]   rb;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  modport slave (
    input  in_valid, in_a, in_b, ry, rb, out_ready,
    output in_ready, ld, a, b, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, ry, rb, out_ready,
    input  in_ready, ld, a, b, out_valid, out_p
  );
endinterface

// File: rtl/mul_seq.sv
// Sequencer for a W-bit shift-add multiplier.
// Accepts one operand pair, pulses ld to load the multiplier, lets it step W times
// (or fewer when EARLY_EXIT is set and its rb register empties), captures ry into
// out_p and holds it on the result handshake until consumed.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mul_seq_if.slave: operand handshake, multiplier drive/feedback, result handshake
// All outputs decode from registered state only.
module mul_seq #(
  parameter int unsigned W          = 4,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input logic   clk,
  input logic   rst,
  mul_seq_if.slave bus
);

  localparam int unsigned CntW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StCapt,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [2*W-1:0] out_p_q, out_p_d;
  logic           rb_empty;

  assign rb_empty = (bus.rb == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      out_p_q <= out_p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    out_p_d = out_p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_a_d  = bus.in_a;
          op_b_d  = bus.in_b;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        // rb is only trusted here: the multiplier was loaded on the LOAD edge.
        if ((cnt_q == CntLast) || (EARLY_EXIT && rb_empty)) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        out_p_d = bus.ry;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.ld        = (state_q == StLoad);
  assign bus.out_valid = (state_q == StDone);
  assign bus.a         = op_a_q;
  assign bus.b         = op_b_q;
  assign bus.out_p     = out_p_q;

endmodule
